scroll_controller: RTL
======================

SCROLL_CONTROLLER -- requirements
Module: scroll_controller

Interface
REQ-001 Parameter FRAMES_PER_LEVEL, default 600, frame ticks per speed increment.
REQ-002 Parameter SPEED_INIT, default 4, speed loaded at reset and at each game start.
REQ-003 Parameter SPEED_MAX, default 12, speed ceiling; legal range SPEED_INIT..15 and below TILE_W.
REQ-004 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse per display frame.
REQ-007 start_btn  input  1  debounced level; only its rising edge is used.
REQ-008 collision  input  1  level from the obstacle/dino overlap logic.
REQ-009 game_status  output  1  high only in RUN; drives the ground scroller enable.
REQ-010 game_over  output  1  high only in OVER.
REQ-011 speed  output  4  current scroll speed in px2 per frame.
REQ-012 ground_offset  output  6  scroll phase within one 40-px2 tile, range 0..39.
REQ-013 tile_advance  output  1  one-cycle pulse when ground_offset wraps past 40.
REQ-014 score  output  16  frames survived in the current game, saturating.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and OVER.
REQ-016 A start edge SHALL be a start_btn high cycle whose previous registered sample was low.
- Transition IDLE -> RUN on a start edge.
- Transition OVER -> RUN on a start edge (restart).
- In both transitions, the same clock edge SHALL load speed=SPEED_INIT, ground_offset=0, score=0 and level counter=0.
REQ-017 RUN -> OVER SHALL occur on the first cycle collision=1; that cycle SHALL NOT apply any frame_tick update (collision wins).
REQ-018 In RUN, each frame_tick SHALL update state as follows:
- sum = ground_offset + speed, computed 7 bits wide.
- If sum >= 40: ground_offset = sum - 40 and tile_advance=1 for that one cycle.
- Otherwise: ground_offset = sum and tile_advance=0.
REQ-019 In RUN, each frame_tick SHALL increment score by 1, holding at 0xFFFF.
REQ-020 In RUN, each frame_tick SHALL advance the level counter.
- When the counter equals FRAMES_PER_LEVEL-1, it SHALL wrap to 0 and speed SHALL increment by 1, saturating at SPEED_MAX.
- A new speed takes effect from the next frame_tick.
REQ-021 frame_tick SHALL be ignored in IDLE and OVER; speed, ground_offset and score SHALL hold their values (the score stays frozen for display).
REQ-022 collision SHALL be ignored in IDLE and OVER; a start edge in RUN SHALL be ignored.
REQ-023 tile_advance SHALL be 0 in every cycle other than the one defined in REQ-018.
REQ-024 All outputs SHALL be registered; response latency SHALL be one clock from the sampled input.
REQ-025 frame_tick and a start edge arriving in the same cycle in IDLE SHALL only start the game; the first scroll update is the next frame_tick.

Reset
REQ-026 rst=1 SHALL immediately force the following, independent of CLK:
- state=IDLE, game_status=0, game_over=0;
- speed=SPEED_INIT, ground_offset=0, tile_advance=0, score=0;
- level counter=0, start sample register=0.
REQ-027 Asserting rst mid-RUN SHALL abandon the game with no pending pulse emitted after release.
REQ-028 After rst deasserts, start_btn already held high SHALL NOT count as a start edge until it has been sampled low.

Structure
REQ-029 A shared package dino_pkg SHALL hold:
- the state enum (IDLE, RUN, OVER);
- TILE_W=40;
- SPEED_W=4, OFFSET_W=6, SCORE_W=16.
REQ-030 The edge detector SHALL be a sub-module named rise_detect (CLK, rst, in, pulse); all other logic SHALL stay flat in scroll_controller.

Verification
REQ-031 Reset, start_btn pulse, 3 frame_ticks -> game_status=1, ground_offset 4,8,12, score=3, tile_advance never high.
REQ-032 RUN with ground_offset=36, speed=4, one frame_tick -> ground_offset=0, tile_advance=1 for exactly one cycle; with speed=5 and offset=38 -> ground_offset=3.
REQ-033 FRAMES_PER_LEVEL=4, 40 frame_ticks -> speed steps 4..12 and holds at 12; score=40.
REQ-034 collision and frame_tick in the same cycle at offset=20 -> game_over=1, ground_offset stays 20, score unchanged; later frame_ticks change nothing.
REQ-035 In OVER, start edge -> RUN with speed=4, offset=0, score=0; start_btn held high through reset release -> stays IDLE.
REQ-036 rst asserted mid-cycle during RUN at speed=9 -> all outputs at reset values before the next CLK edge.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared types and geometry for the endless-runner scroll logic.
package dino_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int TILE_W   = 40;
    localparam int SPEED_W  = 4;
    localparam int OFFSET_W = 6;
    localparam int SCORE_W  = 16;
endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the start button. An edge needs a real low sample
// since reset, so a button held through reset release does not fire.
module rise_detect (
    input  logic CLK,
    input  logic rst,
    input  logic in,
    output logic pulse
);
    logic prev_q;
    logic seen_q;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            prev_q <= in;
            seen_q <= 1'b1;
        end
    end

    assign pulse = in & ~prev_q & seen_q;
endmodule

// File: rtl/scroll_controller.sv
// Game FSM plus ground scroll phase, speed levelling and frame score.
module scroll_controller
    import dino_pkg::*;
#(
    parameter int FRAMES_PER_LEVEL = 600,
    parameter int SPEED_INIT       = 4,
    parameter int SPEED_MAX        = 12
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                start_btn,
    input  logic                collision,
    output logic                game_status,
    output logic                game_over,
    output logic [SPEED_W-1:0]  speed,
    output logic [OFFSET_W-1:0] ground_offset,
    output logic                tile_advance,
    output logic [SCORE_W-1:0]  score
);
    localparam int LVL_W = (FRAMES_PER_LEVEL > 1) ? $clog2(FRAMES_PER_LEVEL) : 1;

    state_t              state_q, state_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                tile_q, tile_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [LVL_W-1:0]    lvl_q, lvl_d;
    logic                start_edge;
    logic [6:0]          sum;

    rise_detect u_start (
        .CLK   (CLK),
        .rst   (rst),
        .in    (start_btn),
        .pulse (start_edge)
    );

    assign sum = {1'b0, offset_q} + {3'b000, speed_q};

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        offset_d = offset_q;
        tile_d   = 1'b0;
        score_d  = score_q;
        lvl_d    = lvl_q;
        case (state_q)
            IDLE, OVER: begin
                // A start edge wins over a same-cycle frame tick.
                if (start_edge) begin
                    state_d  = RUN;
                    speed_d  = SPEED_W'(SPEED_INIT);
                    offset_d = '0;
                    score_d  = '0;
                    lvl_d    = '0;
                end
            end
            RUN: begin
                if (collision) begin
                    state_d = OVER;
                end else if (frame_tick) begin
                    if (sum >= 7'(TILE_W)) begin
                        offset_d = OFFSET_W'(sum - 7'(TILE_W));
                        tile_d   = 1'b1;
                    end else begin
                        offset_d = OFFSET_W'(sum);
                    end
                    if (score_q != '1)
                        score_d = score_q + 1'b1;
                    if (lvl_q == LVL_W'(FRAMES_PER_LEVEL - 1)) begin
                        lvl_d = '0;
                        if (speed_q < SPEED_W'(SPEED_MAX))
                            speed_d = speed_q + 1'b1;
                    end else begin
                        lvl_d = lvl_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            speed_q  <= SPEED_W'(SPEED_INIT);
            offset_q <= '0;
            tile_q   <= 1'b0;
            score_q  <= '0;
            lvl_q    <= '0;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            offset_q <= offset_d;
            tile_q   <= tile_d;
            score_q  <= score_d;
            lvl_q    <= lvl_d;
        end
    end

    assign game_status   = (state_q == RUN);
    assign game_over     = (state_q == OVER);
    assign speed         = speed_q;
    assign ground_offset = offset_q;
    assign tile_advance  = tile_q;
    assign score         = score_q;
endmodule
